// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for one thread's register file write port: ALU vs LSU
// arbitration with starvation guard, pending-load scoreboard and hazard flags.
module regfile_wb_arbiter #(
    parameter int NUM_GP       = 13,
    parameter int STARVE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_valid,
    output logic       alu_ready,
    input  logic [3:0] alu_addr,
    input  logic [7:0] alu_data,
    input  logic       lsu_valid,
    output logic       lsu_ready,
    input  logic [3:0] lsu_addr,
    input  logic [7:0] lsu_data,
    input  logic       issue_load_valid,
    input  logic [3:0] issue_load_addr,
    input  logic [3:0] chk_addr1,
    input  logic [3:0] chk_addr2,
    output logic       hazard,
    output logic       rf_write_enable,
    output logic [3:0] rf_write_addr,
    output logic [7:0] rf_write_data,
    output logic       ro_write_err,
    output logic       starve_active
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

    function automatic logic is_gp(input logic [3:0] a);
        return {1'b0, a} < 5'(NUM_GP);
    endfunction

    logic [NUM_GP-1:0] r_pending;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_we;
    logic [3:0]        r_waddr;
    logic [7:0]        r_wdata;
    logic              r_ro_err;

    logic [NUM_GP-1:0] w_pending_nxt;
    logic [15:0]       w_pend_full;
    logic              w_starve;
    logic              w_alu_block;
    logic              w_alu_go;
    logic              w_lsu_go;
    logic              w_accept;
    logic [3:0]        w_wb_addr;
    logic [7:0]        w_wb_data;

    // Zero-extended to the full address space so read-only addresses look never-pending.
    assign w_pend_full = 16'(r_pending);

    assign w_starve    = (r_wait_cnt == CNT_MAX);
    assign w_alu_block = w_starve || (is_gp(alu_addr) && w_pend_full[alu_addr]);
    assign w_alu_go    = alu_valid && !w_alu_block;
    assign w_lsu_go    = lsu_valid && !w_alu_go;
    assign w_accept    = w_alu_go || w_lsu_go;
    assign w_wb_addr   = w_alu_go ? alu_addr : lsu_addr;
    assign w_wb_data   = w_alu_go ? alu_data : lsu_data;

    assign alu_ready = !w_alu_block;
    assign lsu_ready = !w_alu_go;
    assign hazard    = (is_gp(chk_addr1) && w_pend_full[chk_addr1]) ||
                       (is_gp(chk_addr2) && w_pend_full[chk_addr2]);

    assign rf_write_enable = r_we;
    assign rf_write_addr   = r_waddr;
    assign rf_write_data   = r_wdata;
    assign ro_write_err    = r_ro_err;
    assign starve_active   = w_starve;

    // Set is applied after clear so a newly issued load keeps the register pending.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int unsigned i = 0; i < NUM_GP; i++) begin
            if (w_lsu_go && lsu_addr == 4'(i))
                w_pending_nxt[i] = 1'b0;
            if (issue_load_valid && issue_load_addr == 4'(i))
                w_pending_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending  <= '0;
            r_wait_cnt <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_ro_err   <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;

            if (w_lsu_go || !lsu_valid)
                r_wait_cnt <= '0;
            else if (r_wait_cnt != CNT_MAX)
                r_wait_cnt <= r_wait_cnt + 1'b1;

            r_we     <= w_accept && is_gp(w_wb_addr);
            r_ro_err <= w_accept && !is_gp(w_wb_addr);
            if (w_accept) begin
                r_waddr <= w_wb_addr;
                r_wdata <= w_wb_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized checks of regfile_wb_arbiter against a behavioural
// model of arbitration, starvation, scoreboard and write-port rules.
module tb_regfile_wb_arbiter;

    localparam int NUM_GP       = 13;
    localparam int STARVE_LIMIT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_valid, alu_ready;
    logic [3:0] alu_addr;
    logic [7:0] alu_data;
    logic       lsu_valid, lsu_ready;
    logic [3:0] lsu_addr;
    logic [7:0] lsu_data;
    logic       issue_load_valid;
    logic [3:0] issue_load_addr;
    logic [3:0] chk_addr1, chk_addr2;
    logic       hazard;
    logic       rf_write_enable;
    logic [3:0] rf_write_addr;
    logic [7:0] rf_write_data;
    logic       ro_write_err;
    logic       starve_active;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .NUM_GP       (NUM_GP),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .alu_valid        (alu_valid),
        .alu_ready        (alu_ready),
        .alu_addr         (alu_addr),
        .alu_data         (alu_data),
        .lsu_valid        (lsu_valid),
        .lsu_ready        (lsu_ready),
        .lsu_addr         (lsu_addr),
        .lsu_data         (lsu_data),
        .issue_load_valid (issue_load_valid),
        .issue_load_addr  (issue_load_addr),
        .chk_addr1        (chk_addr1),
        .chk_addr2        (chk_addr2),
        .hazard           (hazard),
        .rf_write_enable  (rf_write_enable),
        .rf_write_addr    (rf_write_addr),
        .rf_write_data    (rf_write_data),
        .ro_write_err     (ro_write_err),
        .starve_active    (starve_active)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit         m_pend [16];
    int         m_wait;
    bit         m_we, m_err;
    bit [3:0]   m_waddr;
    bit [7:0]   m_wdata;
    bit         e_alu_rdy, e_lsu_rdy, e_haz, e_starve;
    bit         alu_took, lsu_took;

    function automatic bit gp(input logic [3:0] a);
        return int'(a) < NUM_GP;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_wait  = 0;
        m_we    = 1'b0;
        m_err   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    task automatic predict();
        bit blocked;
        e_starve  = (m_wait == STARVE_LIMIT);
        blocked   = e_starve || (gp(alu_addr) && m_pend[alu_addr]);
        e_alu_rdy = !blocked;
        alu_took  = alu_valid && !blocked;
        e_lsu_rdy = !alu_took;
        lsu_took  = lsu_valid && e_lsu_rdy;
        e_haz     = (gp(chk_addr1) && m_pend[chk_addr1]) || (gp(chk_addr2) && m_pend[chk_addr2]);
    endtask

    // One clock: combinational checks mid-cycle, model update at the edge, registered checks after.
    task automatic step();
        logic [3:0] a;
        logic [7:0] d;
        @(negedge clk);
        predict();
        chk("alu_ready", 32'(alu_ready), 32'(e_alu_rdy));
        chk("lsu_ready", 32'(lsu_ready), 32'(e_lsu_rdy));
        chk("hazard", 32'(hazard), 32'(e_haz));
        chk("starve_active", 32'(starve_active), 32'(e_starve));
        @(posedge clk);
        if (alu_took || lsu_took) begin
            a = alu_took ? alu_addr : lsu_addr;
            d = alu_took ? alu_data : lsu_data;
            m_we    = gp(a);
            m_err   = !gp(a);
            m_waddr = a;
            m_wdata = d;
        end else begin
            m_we  = 1'b0;
            m_err = 1'b0;
        end
        if (lsu_took && gp(lsu_addr)) m_pend[lsu_addr] = 1'b0;
        if (issue_load_valid && gp(issue_load_addr)) m_pend[issue_load_addr] = 1'b1;
        if (lsu_took || !lsu_valid) m_wait = 0;
        else if (m_wait < STARVE_LIMIT) m_wait++;
        #1;
        chk("rf_write_enable", 32'(rf_write_enable), 32'(m_we));
        chk("rf_write_addr", 32'(rf_write_addr), 32'(m_waddr));
        chk("rf_write_data", 32'(rf_write_data), 32'(m_wdata));
        chk("ro_write_err", 32'(ro_write_err), 32'(m_err));
    endtask

    initial begin
        reset = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
        issue_load_valid = 1'b0; issue_load_addr = '0;
        chk_addr1 = '0; chk_addr2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_we", 32'(rf_write_enable), 32'h0);
        chk("rst_addr", 32'(rf_write_addr), 32'h0);
        chk("rst_data", 32'(rf_write_data), 32'h0);
        chk("rst_err", 32'(ro_write_err), 32'h0);
        chk("rst_starve", 32'(starve_active), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // ALU writes R3 = 0x5A, pulse lasts one cycle
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 8'h5A;
        #1 chk("t1_alu_ready", 32'(alu_ready), 32'h1);
        step();
        chk("t1_we", 32'(rf_write_enable), 32'h1);
        chk("t1_addr", 32'(rf_write_addr), 32'h3);
        chk("t1_data", 32'(rf_write_data), 32'h5A);
        alu_valid = 1'b0;
        step();
        chk("t1_we_drop", 32'(rf_write_enable), 32'h0);

        // Both valid: ALU wins STARVE_LIMIT cycles, then LSU is forced through
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 8'hA1;
        lsu_valid = 1'b1; lsu_addr = 4'd2; lsu_data = 8'hB2;
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            #1 chk("t2_alu_wins", 32'(alu_ready), 32'h1);
            step();
            chk("t2_alu_addr", 32'(rf_write_addr), 32'h1);
        end
        #1;
        chk("t2_starve", 32'(starve_active), 32'h1);
        chk("t2_alu_blocked", 32'(alu_ready), 32'h0);
        chk("t2_lsu_ready", 32'(lsu_ready), 32'h1);
        step();
        chk("t2_lsu_addr", 32'(rf_write_addr), 32'h2);
        chk("t2_lsu_data", 32'(rf_write_data), 32'hB2);
        lsu_valid = 1'b0;
        #1 chk("t2_starve_clr", 32'(starve_active), 32'h0);
        step();
        alu_valid = 1'b0;
        step();

        // Load pending on R7 blocks ALU WAW until the load returns
        issue_load_valid = 1'b1; issue_load_addr = 4'd7;
        step();
        issue_load_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 8'h77; chk_addr1 = 4'd7;
        #1;
        chk("t3_alu_block", 32'(alu_ready), 32'h0);
        chk("t3_lsu_ready", 32'(lsu_ready), 32'h1);
        chk("t3_hazard", 32'(hazard), 32'h1);
        step();
        lsu_valid = 1'b1; lsu_addr = 4'd7; lsu_data = 8'h11;
        step();
        chk("t3_lsu_wr", 32'({rf_write_enable, rf_write_addr, rf_write_data}), 32'h1711);
        lsu_valid = 1'b0;
        #1;
        chk("t3_hazard_clr", 32'(hazard), 32'h0);
        chk("t3_alu_ok", 32'(alu_ready), 32'h1);
        step();
        chk("t3_alu_wr", 32'({rf_write_enable, rf_write_addr, rf_write_data}), 32'h1777);
        alu_valid = 1'b0;
        step();

        // Write to read-only R14
        alu_valid = 1'b1; alu_addr = 4'd14; alu_data = 8'hEE; chk_addr1 = 4'd14;
        #1;
        chk("t4_alu_ready", 32'(alu_ready), 32'h1);
        chk("t4_no_hazard", 32'(hazard), 32'h0);
        step();
        chk("t4_we", 32'(rf_write_enable), 32'h0);
        chk("t4_err", 32'(ro_write_err), 32'h1);
        alu_valid = 1'b0;
        step();
        chk("t4_err_pulse", 32'(ro_write_err), 32'h0);

        // Same-cycle issue and return on R4: set wins
        issue_load_valid = 1'b1; issue_load_addr = 4'd4;
        lsu_valid = 1'b1; lsu_addr = 4'd4; lsu_data = 8'h44;
        step();
        chk("t5_lsu_wr", 32'({rf_write_enable, rf_write_addr, rf_write_data}), 32'h1444);
        issue_load_valid = 1'b0; lsu_valid = 1'b0; chk_addr2 = 4'd4;
        #1 chk("t5_still_pending", 32'(hazard), 32'h1);
        step();

        // Async reset with pending loads and starvation active
        issue_load_valid = 1'b1;
        for (int r = 0; r < 8; r++) begin
            issue_load_addr = 4'(r);
            step();
        end
        issue_load_valid = 1'b0; chk_addr1 = 4'd0;
        alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 8'h99;
        lsu_valid = 1'b1; lsu_addr = 4'd14; lsu_data = 8'hE4;
        repeat (STARVE_LIMIT) step();
        #1;
        chk("t6_starve", 32'(starve_active), 32'h1);
        chk("t6_hazard_pre", 32'(hazard), 32'h1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("t6_async_we", 32'(rf_write_enable), 32'h0);
        chk("t6_async_addr", 32'(rf_write_addr), 32'h0);
        chk("t6_async_data", 32'(rf_write_data), 32'h0);
        chk("t6_async_starve", 32'(starve_active), 32'h0);
        chk("t6_async_hazard", 32'(hazard), 32'h0);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();

        // Randomized traffic; sources hold their transfer while valid && !ready
        for (int c = 0; c < 400; c++) begin
            if (!(alu_valid && !alu_took)) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_addr  = 4'($urandom_range(0, 15));
                alu_data  = 8'($urandom);
            end
            if (!(lsu_valid && !lsu_took)) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_addr  = 4'($urandom_range(0, 15));
                lsu_data  = 8'($urandom);
            end
            issue_load_valid = ($urandom_range(0, 3) == 0);
            issue_load_addr  = 4'($urandom_range(0, 15));
            chk_addr1        = 4'($urandom_range(0, 15));
            chk_addr2        = 4'($urandom_range(0, 15));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
